aes_key_schedule: RTL and testbench
===================================

# aes_key_schedule

Sequential AES-128 key expansion that accepts one cipher key and streams the 11 round keys, one per handshake, to the round datapath. It sits directly upstream of the per-round encryption stage and drives that stage's `Key` and `Last` inputs, one round key per round. Each round key is derived from the previous one by a single RotWord/SubWord/Rcon step. An optional build adds reverse-order delivery for the decryption path.

## Interface
- No parameters. Block and key width are `AES_BLOCK_SIZE` (128) from `aes_defines.svh`.
- Clk  input  1  single clock; all state is updated on the rising edge.
- Rst  input  1  reset, asynchronous, active-high.
- Key_valid  input  1  cipher key on `Key` is valid.
- Key_ready  output  1  block can accept a new cipher key.
- Key  input  128  cipher key, in FIPS-197 byte order (byte 0 at bits [127:120]).
- Reverse  input  1  sampled with the key; 1 = deliver keys round 10 down to round 0. Present only with `AES_KEY_REVERSE_EN`.
- Rk_valid  output  1  `Rk` holds a valid round key.
- Rk_ready  input  1  consumer accepts the round key.
- Rk  output  128  current round key.
- Rk_round  output  4  index of the round key on `Rk` (0–10).
- Rk_last  output  1  the key on `Rk` is the final key of the stream.
- Busy  output  1  a key stream is in progress.

## Operation
- A transfer occurs on a port in any cycle where both its valid and its ready are 1.
- States:
  - IDLE: `Key_ready`=1. A key handshake captures `Key` into `Rk`, sets `Rk_round`=0 and `Rcon`=0x01, then moves to EMIT (or to EXPAND when `Reverse`=1).
  - EMIT: `Rk_valid`=1. On each `Rk` handshake:
    - If the key is not the last, load the next key and step the round: forward ±1 by direction.
    - If the key is the last, go to IDLE.
  - EXPAND (reverse builds only): computes one key per cycle into an 11×128 store, takes 10 cycles, then enters EMIT at round 10.
- Next-key step:
  - w4 = w0 ^ SubWord(RotWord(w3)) ^ {Rcon, 24'h0}
  - w5 = w1 ^ w4; w6 = w2 ^ w5; w7 = w3 ^ w6
  - `Rcon` is multiplied by x in GF(2^8) with reduction polynomial 0x1B. Sequence: 01,02,04,08,10,20,40,80,1B,36.
- `Rk_last`=1 exactly when `Rk_round`=10 (forward) or `Rk_round`=0 (reverse).
- `Busy`=1 in EXPAND and EMIT; 0 in IDLE.
- `Key_valid` is ignored outside IDLE. A new key is never captured mid-stream.

## Timing
- Reset values:
  - `Key_ready`=1, `Rk_valid`=0, `Rk`=0, `Rk_round`=0, `Rk_last`=0, `Busy`=0.
  - State = IDLE, `Rcon`=0x01.
- All outputs are registered. No combinational path exists from `Rk_ready` or `Key_valid` to any output.
- Forward latency:
  - Key handshake in cycle t gives `Rk_valid`=1 with round 0 at t+1.
  - With `Rk_ready` held at 1, rounds 1–10 follow on consecutive cycles, so round 10 is visible at t+11.
- Reverse latency: key handshake in cycle t gives round 10 visible at t+11. Round 0 is visible at t+21 with `Rk_ready` held.
- Stall: while `Rk_valid`=1 and `Rk_ready`=0, `Rk`, `Rk_round` and `Rk_last` hold stable.
- End of stream: the last `Rk` handshake in cycle u gives `Rk_valid`=0 and `Key_ready`=1 at u+1. There is no back-to-back overlap between streams.
- Reset mid-stream: all state clears immediately (asynchronously). The partial stream is abandoned, and the consumer sees `Rk_valid` drop with no further keys.

## Configuration
- `AES_KEY_REVERSE_EN` defined:
  - `Reverse` port present.
  - EXPAND state and 11×128 key store are built.
  - Reverse delivery is available.
- `AES_KEY_REVERSE_EN` undefined:
  - No `Reverse` port, no key store, no EXPAND state.
  - Forward streaming only: each key is computed on the fly from the previous one.

## Test plan
- Forward FIPS-197 key (Key=2b7e151628aed2a6abf7158809cf4f3c), `Rk_ready`=1:
  - Round 0 = that key at t+1.
  - Round 1 = a0fafe1788542cb123a339392a6c7605 at t+2.
  - Round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 at t+11 with `Rk_last`=1.
  - `Key_ready`=1 at t+12.
- Random `Rk_ready` stalls during the same stream: identical 11 keys in order, outputs stable throughout every stall, exactly 11 handshakes.
- Second `Key_valid` pulsed mid-stream: ignored; the first stream completes unchanged.
- `Rst` asserted at round 5: outputs return to reset values in the same cycle. A fresh key afterwards restarts cleanly at round 0.
- All-zero key: round 1 = 62636363626363636263636362636363; round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- With `AES_KEY_REVERSE_EN` and Reverse=1, FIPS key:
  - First key d014…0ca6 with `Rk_round`=10 at t+11.
  - Last key 2b7e…4f3c with `Rk_round`=0 and `Rk_last`=1.

Source files
------------

// File: rtl/aes_key_schedule.sv
// AES-128 key schedule: streams round keys 0..10 one per Rk handshake.
// Optional AES_KEY_REVERSE_EN adds a Reverse input that delivers round 10 down to round 0.
`ifndef AES_BLOCK_SIZE
`define AES_BLOCK_SIZE 128
`endif

module aes_key_schedule (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic                       Key_valid,
  output logic                       Key_ready,
  input  logic [`AES_BLOCK_SIZE-1:0] Key,
`ifdef AES_KEY_REVERSE_EN
  input  logic                       Reverse,
`endif
  output logic                       Rk_valid,
  input  logic                       Rk_ready,
  output logic [`AES_BLOCK_SIZE-1:0] Rk,
  output logic [3:0]                 Rk_round,
  output logic                       Rk_last,
  output logic                       Busy
);
  localparam int KW = `AES_BLOCK_SIZE;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EMIT   = 2'd1
`ifdef AES_KEY_REVERSE_EN
    ,EXPAND = 2'd2
`endif
  } state_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box built from its definition: inverse via x^254, then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [KW-1:0] next_key(input logic [KW-1:0] k, input logic [7:0] rcon);
    logic [31:0] w0, w1, w2, w3, rot, sub, w4, w5, w6, w7;
    {w0, w1, w2, w3} = k;
    rot = {w3[23:0], w3[31:24]};
    sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    w4  = w0 ^ sub ^ {rcon, 24'h0};
    w5  = w1 ^ w4;
    w6  = w2 ^ w5;
    w7  = w3 ^ w6;
    return {w4, w5, w6, w7};
  endfunction

  state_t          state_reg;
  logic            key_ready_reg;
  logic            rk_valid_reg;
  logic [KW-1:0]   rk_reg;
  logic [3:0]      round_reg;
  logic            last_reg;
  logic            busy_reg;
  logic [7:0]      rcon_reg;
  logic [KW-1:0]   rk_next;
  logic [7:0]      rcon_next;

  assign rk_next   = next_key(rk_reg, rcon_reg);
  assign rcon_next = {rcon_reg[6:0], 1'b0} ^ (rcon_reg[7] ? 8'h1b : 8'h00);

`ifdef AES_KEY_REVERSE_EN
  logic            rev_reg;
  logic [KW-1:0]   key_store [0:10];

  // Rounds 0..9 are stored while expanding; round 10 stays in rk_reg for the first emit.
  always_ff @(posedge Clk) begin
    if (state_reg == EXPAND) key_store[round_reg] <= rk_reg;
  end
`endif

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_reg     <= IDLE;
      key_ready_reg <= 1'b1;
      rk_valid_reg  <= 1'b0;
      rk_reg        <= '0;
      round_reg     <= 4'd0;
      last_reg      <= 1'b0;
      busy_reg      <= 1'b0;
      rcon_reg      <= 8'h01;
`ifdef AES_KEY_REVERSE_EN
      rev_reg       <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (Key_valid) begin
            rk_reg        <= Key;
            round_reg     <= 4'd0;
            rcon_reg      <= 8'h01;
            key_ready_reg <= 1'b0;
            busy_reg      <= 1'b1;
`ifdef AES_KEY_REVERSE_EN
            rev_reg       <= Reverse;
            if (Reverse) begin
              state_reg <= EXPAND;
            end else begin
              state_reg    <= EMIT;
              rk_valid_reg <= 1'b1;
            end
`else
            state_reg     <= EMIT;
            rk_valid_reg  <= 1'b1;
`endif
          end
        end
        EMIT: begin
          if (Rk_ready) begin
            if (last_reg) begin
              state_reg     <= IDLE;
              rk_valid_reg  <= 1'b0;
              last_reg      <= 1'b0;
              key_ready_reg <= 1'b1;
              busy_reg      <= 1'b0;
            end
`ifdef AES_KEY_REVERSE_EN
            else if (rev_reg) begin
              rk_reg    <= key_store[round_reg - 4'd1];
              round_reg <= round_reg - 4'd1;
              last_reg  <= (round_reg == 4'd1);
            end
`endif
            else begin
              rk_reg    <= rk_next;
              rcon_reg  <= rcon_next;
              round_reg <= round_reg + 4'd1;
              last_reg  <= (round_reg == 4'd9);
            end
          end
        end
`ifdef AES_KEY_REVERSE_EN
        EXPAND: begin
          rk_reg    <= rk_next;
          rcon_reg  <= rcon_next;
          round_reg <= round_reg + 4'd1;
          if (round_reg == 4'd9) begin
            state_reg    <= EMIT;
            rk_valid_reg <= 1'b1;
          end
        end
`endif
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign Key_ready = key_ready_reg;
  assign Rk_valid  = rk_valid_reg;
  assign Rk        = rk_reg;
  assign Rk_round  = round_reg;
  assign Rk_last   = last_reg;
  assign Busy      = busy_reg;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench for aes_key_schedule against a word-wise FIPS-197 expansion model.
// Reverse-order tests are compiled in when AES_KEY_REVERSE_EN is defined.
module tb_aes_key_schedule;
  logic         Clk = 1'b0;
  logic         Rst;
  logic         Key_valid;
  logic         Key_ready;
  logic [127:0] Key;
`ifdef AES_KEY_REVERSE_EN
  logic         Reverse;
`endif
  logic         Rk_valid;
  logic         Rk_ready;
  logic [127:0] Rk;
  logic [3:0]   Rk_round;
  logic         Rk_last;
  logic         Busy;

  int errors = 0;
  int checks = 0;

  aes_key_schedule dut (
    .Clk(Clk), .Rst(Rst), .Key_valid(Key_valid), .Key_ready(Key_ready), .Key(Key),
`ifdef AES_KEY_REVERSE_EN
    .Reverse(Reverse),
`endif
    .Rk_valid(Rk_valid), .Rk_ready(Rk_ready), .Rk(Rk), .Rk_round(Rk_round),
    .Rk_last(Rk_last), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  logic [7:0] sbox_t [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16};
  logic [7:0]   rcon_t [11] = '{8'h00,8'h01,8'h02,8'h04,8'h08,8'h10,8'h20,8'h40,8'h80,8'h1b,8'h36};
  logic [127:0] ref_keys [11];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Textbook word-array expansion w[0..43].
  task automatic model_keys(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rcon_t[i/4], 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) ref_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic run_stream(input logic [127:0] k, input bit rev, input int stall_pct,
                            input bit check_lat, input bit inject, input bit use_fixed,
                            input logic [127:0] fx1, input logic [127:0] fx10);
    int n, cyc, er;
    bit hs, seen;
    model_keys(k);
    check("key_ready_idle", Key_ready, 1);
    check("busy_idle", Busy, 0);
    Key = k;
    Key_valid = 1'b1;
`ifdef AES_KEY_REVERSE_EN
    Reverse = rev;
`endif
    @(posedge Clk); #1;
    Key_valid = 1'b0;
    Key = {$urandom, $urandom, $urandom, $urandom};
    n = 0; cyc = 1; seen = 0;
    while (n < 11 && cyc < 300) begin
      er = rev ? 10 - n : n;
      if (Rk_valid) begin
        check("rk", Rk, ref_keys[er]);
        check("rk_round", Rk_round, er);
        check("rk_last", Rk_last, rev ? (er == 0) : (er == 10));
        if (use_fixed && er == 1)  check("fixed_round1", Rk, fx1);
        if (use_fixed && er == 10) check("fixed_round10", Rk, fx10);
        if (check_lat && n == 0)  check("first_key_latency", cyc, rev ? 11 : 1);
        if (check_lat && n == 10) check("last_key_latency", cyc, rev ? 21 : 11);
        seen = 1;
      end else if (seen) begin
        check("rk_valid_hold", Rk_valid, 1);
      end
      check("busy_stream", Busy, 1);
      check("key_ready_stream", Key_ready, 0);
      Key_valid = inject && (cyc == 4 || cyc == 5);
      Rk_ready = ($urandom_range(99) >= stall_pct);
      hs = Rk_valid && Rk_ready;
      @(posedge Clk); #1;
      cyc++;
      if (hs) n++;
    end
    Key_valid = 1'b0;
    Rk_ready = 1'b0;
    check("handshake_count", n, 11);
    check("end_rk_valid", Rk_valid, 0);
    check("end_key_ready", Key_ready, 1);
    check("end_busy", Busy, 0);
    $display("stream key=%h rev=%0d stall=%0d inject=%0d handshakes=%0d cycles=%0d",
             k, rev, stall_pct, inject, n, cyc);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_key_ready"}, Key_ready, 1);
    check({tag, "_rk_valid"}, Rk_valid, 0);
    check({tag, "_rk"}, Rk, 0);
    check({tag, "_rk_round"}, Rk_round, 0);
    check({tag, "_rk_last"}, Rk_last, 0);
    check({tag, "_busy"}, Busy, 0);
  endtask

  initial begin
    int guard;
    logic [127:0] rk_key;
    Rst = 1'b1; Key_valid = 1'b0; Key = '0; Rk_ready = 1'b0;
`ifdef AES_KEY_REVERSE_EN
    Reverse = 1'b0;
`endif
    repeat (2) @(posedge Clk);
    #1;
    check_reset_outputs("reset");
    Rst = 1'b0;
    @(posedge Clk); #1;

    // FIPS-197 key, no stalls, with latency and published round keys.
    run_stream(FIPS_KEY, 0, 0, 1, 0, 1, FIPS_R1, FIPS_R10);
    // Same key with random consumer stalls.
    run_stream(FIPS_KEY, 0, 40, 0, 0, 1, FIPS_R1, FIPS_R10);
    // Second key pulsed mid-stream must be ignored.
    run_stream(FIPS_KEY, 0, 20, 0, 1, 1, FIPS_R1, FIPS_R10);

    // Asynchronous reset at round 5.
    Key = FIPS_KEY; Key_valid = 1'b1;
    @(posedge Clk); #1;
    Key_valid = 1'b0; Rk_ready = 1'b1;
    guard = 0;
    while (!(Rk_valid && Rk_round == 4'd5) && guard < 20) begin
      @(posedge Clk); #1;
      guard++;
    end
    check("reach_round5", Rk_round, 5);
    Rst = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    @(posedge Clk); #1;
    Rst = 1'b0;
    @(posedge Clk); #1;
    check("post_reset_rk_valid", Rk_valid, 0);
    Rk_ready = 1'b0;
    $display("reset at round 5 applied");
    run_stream(FIPS_KEY, 0, 0, 1, 0, 1, FIPS_R1, FIPS_R10);

    // All-zero key.
    run_stream(128'h0, 0, 0, 1, 0, 1, ZERO_R1, ZERO_R10);

    for (int i = 0; i < 6; i++) begin
      rk_key = {$urandom, $urandom, $urandom, $urandom};
      run_stream(rk_key, 0, $urandom_range(60), 0, (i % 2 == 1), 0, '0, '0);
    end

`ifdef AES_KEY_REVERSE_EN
    run_stream(FIPS_KEY, 1, 0, 1, 0, 1, FIPS_R1, FIPS_R10);
    run_stream(FIPS_KEY, 1, 40, 0, 1, 1, FIPS_R1, FIPS_R10);
    for (int i = 0; i < 4; i++) begin
      rk_key = {$urandom, $urandom, $urandom, $urandom};
      run_stream(rk_key, $urandom_range(1), $urandom_range(50), 0, 0, 0, '0, '0);
    end
    run_stream(FIPS_KEY, 0, 0, 1, 0, 1, FIPS_R1, FIPS_R10);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
